riscv_core_div_out: RTL and testbench

Post-divider result conditioning stage for the RV64M iterative divider. Captures operand signs, opcode and special-case flags when a divide is issued, then waits for the unsigned quotient/remainder magnitudes from the divider core. Applies sign restoration, RISC-V divide-by-zero and overflow results, and 32-bit word sign extension. Presents the final register-file value through a valid/ready handshake to the writeback stage.

---
 rtl/riscv_core_div_out_if.sv | 50 +++++
 rtl/riscv_core_div_out.sv | 158 +++++++++++++++
 tb/tb_riscv_core_div_out.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_core_div_out_if.sv
// riscv_core_div_out_if
//   Bundles the issue, divider-core and writeback signals of the RV64M
//   divider output conditioning stage.
//
//   Issue side      : i_div_out_start, i_div_out_srcA, i_div_out_srcB,
//                     i_div_out_control, i_div_out_isword, o_div_out_busy,
//                     o_div_out_special
//   Divider core    : i_div_out_done, i_div_out_quotient, i_div_out_remainder
//   Writeback side  : o_div_out_valid, o_div_out_result, i_div_out_ready
//
//   Writeback handshake: o_div_out_valid rises only for a captured operation
//   and then stays high with o_div_out_result unchanged until a rising edge
//   sees valid & ready together; that edge is the single transfer, and valid
//   is low in the following cycle. ready may toggle freely while valid is low.
//
//   modport master : the surrounding pipeline (drives the i_* signals)
//   modport slave  : the conditioning stage (drives the o_* signals)
interface riscv_core_div_out_if #(
  parameter int XLEN = 64
);
  logic            i_div_out_start;
  logic [XLEN-1:0] i_div_out_srcA;
  logic [XLEN-1:0] i_div_out_srcB;
  logic [1:0]      i_div_out_control;
  logic            i_div_out_isword;
  logic            i_div_out_done;
  logic [XLEN-1:0] i_div_out_quotient;
  logic [XLEN-1:0] i_div_out_remainder;
  logic            i_div_out_ready;
  logic            o_div_out_busy;
  logic            o_div_out_special;
  logic            o_div_out_valid;
  logic [XLEN-1:0] o_div_out_result;

  modport master (
    output i_div_out_start, i_div_out_srcA, i_div_out_srcB,
           i_div_out_control, i_div_out_isword, i_div_out_done,
           i_div_out_quotient, i_div_out_remainder, i_div_out_ready,
    input  o_div_out_busy, o_div_out_special, o_div_out_valid,
           o_div_out_result
  );

  modport slave (
    input  i_div_out_start, i_div_out_srcA, i_div_out_srcB,
           i_div_out_control, i_div_out_isword, i_div_out_done,
           i_div_out_quotient, i_div_out_remainder, i_div_out_ready,
    output o_div_out_busy, o_div_out_special, o_div_out_valid,
           o_div_out_result
  );
endinterface

// File: rtl/riscv_core_div_out.sv
// riscv_core_div_out
//   Result conditioning after the unsigned iterative divider. On issue it
//   captures opcode, operand signs and the divide-by-zero / signed-overflow
//   flags; when the core reports done it restores signs, substitutes the
//   RISC-V special results and sign-extends W-variant results, then holds
//   the value for writeback under a valid/ready handshake.
//
//   Ports:
//     i_clk           clock, rising edge
//     i_rst           synchronous active-high reset
//     bus             riscv_core_div_out_if.slave (issue/core/writeback)
//     o_div_out_state FSM state for observation (0 IDLE, 1 WAIT, 2 VALID)
//
//   Optional feature: define DIV_OUT_BYPASS_EN to let divide-by-zero and
//   overflow ops skip the divider core and go IDLE->VALID in one cycle.
module riscv_core_div_out #(
  parameter int XLEN = 64
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  riscv_core_div_out_if.slave  bus,
  output logic [1:0]           o_div_out_state
);
  localparam int HW = XLEN / 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      ctrl_q;
  logic            isword_q, signa_q, signb_q, dz_q, ovf_q;
  logic [XLEN-1:0] rawa_q;
  logic [XLEN-1:0] result_q, result_d;
  logic            capture_en;

  // Issue-time decode of the raw operands
  logic            cap_signa, cap_signb, cap_dz, cap_ovf, cap_uns;
  logic [XLEN-1:0] cap_rawa;

  always_comb begin
    cap_uns = bus.i_div_out_control[0];
    if (bus.i_div_out_isword) begin
      cap_signa = !cap_uns && bus.i_div_out_srcA[HW-1];
      cap_signb = !cap_uns && bus.i_div_out_srcB[HW-1];
      cap_dz    = (bus.i_div_out_srcB[HW-1:0] == '0);
      cap_ovf   = !cap_uns && (bus.i_div_out_srcA[HW-1:0] == {1'b1, {(HW-1){1'b0}}})
                  && (&bus.i_div_out_srcB[HW-1:0]);
      cap_rawa  = {{HW{1'b0}}, bus.i_div_out_srcA[HW-1:0]};
    end else begin
      cap_signa = !cap_uns && bus.i_div_out_srcA[XLEN-1];
      cap_signb = !cap_uns && bus.i_div_out_srcB[XLEN-1];
      cap_dz    = (bus.i_div_out_srcB == '0);
      cap_ovf   = !cap_uns && (bus.i_div_out_srcA == {1'b1, {(XLEN-1){1'b0}}})
                  && (&bus.i_div_out_srcB);
      cap_rawa  = bus.i_div_out_srcA;
    end
  end

  // Final rd value. Negation is done at full width; for W ops only the low
  // half is kept, which equals the half-width two's complement.
  function automatic logic [XLEN-1:0] fixup(
    input logic [1:0]      ctrl,
    input logic            isword,
    input logic            signa,
    input logic            signb,
    input logic            dz,
    input logic            ovf,
    input logic [XLEN-1:0] rawa,
    input logic [XLEN-1:0] q,
    input logic [XLEN-1:0] r
  );
    logic [XLEN-1:0] quo, rem, sel;
    if (dz) begin
      quo = '1;
      rem = rawa;
    end else if (ovf) begin
      quo = rawa;
      rem = '0;
    end else begin
      quo = (signa ^ signb) ? -q : q;
      rem = signa ? -r : r;
    end
    sel = ctrl[1] ? rem : quo;
    if (isword) fixup = {{HW{sel[HW-1]}}, sel[HW-1:0]};
    else        fixup = sel;
  endfunction

  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    capture_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.i_div_out_start) begin
          capture_en = 1'b1;
          state_d    = S_WAIT;
`ifdef DIV_OUT_BYPASS_EN
          // Special results need no core data; finish immediately.
          if (cap_dz || cap_ovf) begin
            state_d  = S_VALID;
            result_d = fixup(bus.i_div_out_control, bus.i_div_out_isword,
                             cap_signa, cap_signb, cap_dz, cap_ovf, cap_rawa,
                             '0, '0);
          end
`endif
        end
      end
      S_WAIT: begin
        // Core buses are only meaningful in the done cycle.
        if (bus.i_div_out_done) begin
          state_d  = S_VALID;
          result_d = fixup(ctrl_q, isword_q, signa_q, signb_q, dz_q, ovf_q,
                           rawa_q, bus.i_div_out_quotient,
                           bus.i_div_out_remainder);
        end
      end
      S_VALID: begin
        if (bus.i_div_out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      ctrl_q   <= '0;
      isword_q <= 1'b0;
      signa_q  <= 1'b0;
      signb_q  <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      rawa_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      if (capture_en) begin
        ctrl_q   <= bus.i_div_out_control;
        isword_q <= bus.i_div_out_isword;
        signa_q  <= cap_signa;
        signb_q  <= cap_signb;
        dz_q     <= cap_dz;
        ovf_q    <= cap_ovf;
        rawa_q   <= cap_rawa;
      end
    end
  end

  assign bus.o_div_out_busy    = (state_q != S_IDLE);
  assign bus.o_div_out_valid   = (state_q == S_VALID);
  assign bus.o_div_out_special = dz_q | ovf_q;
  assign bus.o_div_out_result  = result_q;
  assign o_div_out_state       = state_q;
endmodule

// File: tb/tb_riscv_core_div_out.sv
module tb_riscv_core_div_out;
  localparam int XLEN = 64;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic [1:0] dbg_state;

  riscv_core_div_out_if #(.XLEN(XLEN)) bus ();

  riscv_core_div_out #(.XLEN(XLEN)) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .bus             (bus),
    .o_div_out_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 i_clk = ~i_clk;

  // ---------------- scoreboard ----------------
  int n_vec  = 0;
  int n_miss = 0;
  logic [XLEN-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // ---------------- reference model (RISC-V M semantics) ----------------
  function automatic logic [63:0] ref_result(input logic [1:0] ctrl,
      input logic isw, input logic [63:0] a, input logic [63:0] b);
    logic [31:0] a32, b32, r32;
    logic [63:0] r64;
    a32 = a[31:0];
    b32 = b[31:0];
    if (isw) begin
      if (b32 == 0)
        r32 = ctrl[1] ? a32 : 32'hFFFF_FFFF;
      else if (!ctrl[0] && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF)
        r32 = ctrl[1] ? 32'h0 : a32;
      else if (ctrl[0])
        r32 = ctrl[1] ? a32 % b32 : a32 / b32;
      else
        r32 = ctrl[1] ? $signed(a32) % $signed(b32) : $signed(a32) / $signed(b32);
      return {{32{r32[31]}}, r32};
    end
    if (b == 0)
      r64 = ctrl[1] ? a : 64'hFFFF_FFFF_FFFF_FFFF;
    else if (!ctrl[0] && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF)
      r64 = ctrl[1] ? 64'h0 : a;
    else if (ctrl[0])
      r64 = ctrl[1] ? a % b : a / b;
    else
      r64 = ctrl[1] ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
    return r64;
  endfunction

  function automatic logic ref_special(input logic [1:0] ctrl, input logic isw,
      input logic [63:0] a, input logic [63:0] b);
    if (isw)
      return (b[31:0] == 0) ||
             (!ctrl[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
    return (b == 0) ||
           (!ctrl[0] && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF);
  endfunction

  // Unsigned magnitudes an ideal divider core would return.
  task automatic core_vals(input logic [1:0] ctrl, input logic isw,
      input logic [63:0] a, input logic [63:0] b,
      output logic [63:0] q, output logic [63:0] r);
    logic [31:0] ma32, mb32;
    logic [63:0] ma, mb;
    if (isw) begin
      ma32 = (!ctrl[0] && a[31]) ? -a[31:0] : a[31:0];
      mb32 = (!ctrl[0] && b[31]) ? -b[31:0] : b[31:0];
      if (mb32 == 0) begin q = rnd64(); r = rnd64(); end
      else begin q = {32'h0, ma32 / mb32}; r = {32'h0, ma32 % mb32}; end
    end else begin
      ma = (!ctrl[0] && a[63]) ? -a : a;
      mb = (!ctrl[0] && b[63]) ? -b : b;
      if (mb == 0) begin q = rnd64(); r = rnd64(); end
      else begin q = ma / mb; r = ma % mb; end
    end
  endtask

  // ---------------- driver ----------------
  // Entered and left at a falling edge with the stage idle.
  task automatic do_op(input string tag, input logic [1:0] ctrl,
      input logic isw, input logic [63:0] a, input logic [63:0] b,
      input logic [63:0] q, input logic [63:0] r, input logic [63:0] exp_res,
      input logic exp_sp, input int lat, input int hold, input bit inject);
    logic [63:0] want;
    bit bypassed;
    bypassed = 1'b0;
    exp_q.push_back(exp_res);
    check_eq({tag, ".idle_busy"}, bus.o_div_out_busy, 64'd0);
    bus.i_div_out_start   = 1'b1;
    bus.i_div_out_control = ctrl;
    bus.i_div_out_isword  = isw;
    bus.i_div_out_srcA    = a;
    bus.i_div_out_srcB    = b;
    @(posedge i_clk); #1;
    bus.i_div_out_start   = 1'b0;
    bus.i_div_out_srcA    = rnd64();
    bus.i_div_out_srcB    = 64'd0;
    bus.i_div_out_control = 2'($urandom_range(0, 3));
    bus.i_div_out_isword  = 1'($urandom_range(0, 1));
    @(negedge i_clk);
    check_eq({tag, ".busy"}, bus.o_div_out_busy, 64'd1);
    check_eq({tag, ".special"}, bus.o_div_out_special, {63'd0, exp_sp});
`ifdef DIV_OUT_BYPASS_EN
    if (exp_sp) bypassed = 1'b1;
`endif
    if (!bypassed) begin
      for (int i = 0; i < lat; i++) begin
        check_eq({tag, ".wait_valid"}, bus.o_div_out_valid, 64'd0);
        @(negedge i_clk);
      end
      bus.i_div_out_done      = 1'b1;
      bus.i_div_out_quotient  = q;
      bus.i_div_out_remainder = r;
      if (hold == 0) bus.i_div_out_ready = 1'b1;
      @(posedge i_clk); #1;
      bus.i_div_out_done      = 1'b0;
      bus.i_div_out_quotient  = rnd64();
      bus.i_div_out_remainder = rnd64();
      @(negedge i_clk);
    end else if (hold == 0) begin
      bus.i_div_out_ready = 1'b1;
    end
    want = exp_q.pop_front();
    check_eq({tag, ".valid"}, bus.o_div_out_valid, 64'd1);
    check_eq({tag, ".result"}, bus.o_div_out_result, want);
    for (int i = 0; i < hold; i++) begin
      if (inject && i == 1) begin
        bus.i_div_out_start   = 1'b1;
        bus.i_div_out_control = 2'b01;
        bus.i_div_out_srcA    = rnd64();
        bus.i_div_out_srcB    = 64'd0;
      end
      @(negedge i_clk);
      bus.i_div_out_start = 1'b0;
      check_eq({tag, ".hold_valid"}, bus.o_div_out_valid, 64'd1);
      check_eq({tag, ".hold_busy"}, bus.o_div_out_busy, 64'd1);
      check_eq({tag, ".hold_result"}, bus.o_div_out_result, want);
      check_eq({tag, ".hold_special"}, bus.o_div_out_special, {63'd0, exp_sp});
    end
    bus.i_div_out_ready = 1'b1;
    @(posedge i_clk); #1;
    bus.i_div_out_ready = 1'b0;
    @(negedge i_clk);
    check_eq({tag, ".post_valid"}, bus.o_div_out_valid, 64'd0);
    check_eq({tag, ".post_busy"}, bus.o_div_out_busy, 64'd0);
    check_eq({tag, ".post_state"}, dbg_state, 64'd0);
  endtask

  task automatic model_op(input string tag, input logic [1:0] ctrl,
      input logic isw, input logic [63:0] a, input logic [63:0] b,
      input int lat, input int hold);
    logic [63:0] q, r;
    core_vals(ctrl, isw, a, b, q, r);
    do_op(tag, ctrl, isw, a, b, q, r, ref_result(ctrl, isw, a, b),
          ref_special(ctrl, isw, a, b), lat, hold, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0]  ctrl;
    logic        isw;
    logic [63:0] a, b;
    int          kind;

    i_rst = 1'b1;
    bus.i_div_out_start     = 1'b0;
    bus.i_div_out_srcA      = '0;
    bus.i_div_out_srcB      = '0;
    bus.i_div_out_control   = '0;
    bus.i_div_out_isword    = 1'b0;
    bus.i_div_out_done      = 1'b0;
    bus.i_div_out_quotient  = '0;
    bus.i_div_out_remainder = '0;
    bus.i_div_out_ready     = 1'b0;
    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(negedge i_clk);
    check_eq("rst.busy", bus.o_div_out_busy, 64'd0);
    check_eq("rst.valid", bus.o_div_out_valid, 64'd0);
    check_eq("rst.special", bus.o_div_out_special, 64'd0);
    check_eq("rst.result", bus.o_div_out_result, 64'd0);
    check_eq("rst.state", dbg_state, 64'd0);

    // Directed vectors
    do_op("div_neg", 2'b00, 1'b0, -64'sd7, 64'd2, 64'd3, 64'd1,
          64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 0, 0, 1'b0);
    do_op("rem_neg", 2'b10, 1'b0, -64'sd7, 64'd2, 64'd3, 64'd1,
          64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0, 0, 1'b0);
    do_op("divuw", 2'b01, 1'b1, 64'hDEAD_BEEF_8000_0000, 64'h1234_0000_0000_0002,
          64'h4000_0000, 64'h0, 64'h0000_0000_4000_0000, 1'b0, 1, 0, 1'b0);
    do_op("remuw", 2'b11, 1'b1, 64'hDEAD_BEEF_8000_0000, 64'h1234_0000_0000_0002,
          64'h4000_0000, 64'h8000_0001, 64'hFFFF_FFFF_8000_0001, 1'b0, 2, 0, 1'b0);
    do_op("div_dz", 2'b00, 1'b0, 64'd5, 64'd0, rnd64(), rnd64(),
          64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0, 0, 1'b0);
    do_op("remw_dz", 2'b10, 1'b1, 64'h1_8000_0000, 64'hABCD_0000_0000_0000,
          rnd64(), rnd64(), 64'hFFFF_FFFF_8000_0000, 1'b1, 1, 0, 1'b0);
    do_op("div_ovf", 2'b00, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
          rnd64(), rnd64(), 64'h8000_0000_0000_0000, 1'b1, 0, 0, 1'b0);
    do_op("remw_ovf", 2'b10, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF,
          rnd64(), rnd64(), 64'h0, 1'b1, 0, 0, 1'b0);
    // Backpressure with a stray start during the hold
    do_op("bp", 2'b01, 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 64'd14, 1'b0, 1, 5, 1'b1);

    // Reset while waiting on the core, then a late done
    bus.i_div_out_start   = 1'b1;
    bus.i_div_out_control = 2'b00;
    bus.i_div_out_isword  = 1'b0;
    bus.i_div_out_srcA    = 64'd50;
    bus.i_div_out_srcB    = 64'd5;
    @(posedge i_clk); #1 bus.i_div_out_start = 1'b0;
    @(negedge i_clk);
    check_eq("mid.state_wait", dbg_state, 64'd1);
    i_rst = 1'b1;
    @(posedge i_clk); #1 i_rst = 1'b0;
    bus.i_div_out_done     = 1'b1;
    bus.i_div_out_quotient = 64'd10;
    bus.i_div_out_ready    = 1'b1;
    @(posedge i_clk); #1 bus.i_div_out_done = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge i_clk);
      check_eq("mid.valid", bus.o_div_out_valid, 64'd0);
      check_eq("mid.busy", bus.o_div_out_busy, 64'd0);
      check_eq("mid.special", bus.o_div_out_special, 64'd0);
      check_eq("mid.result", bus.o_div_out_result, 64'd0);
    end
    bus.i_div_out_ready = 1'b0;
    do_op("divu_after_rst", 2'b01, 1'b0, 64'd10, 64'd3, 64'd3, 64'd1, 64'd3,
          1'b0, 0, 0, 1'b0);

    // Randomized vectors against the model
    for (int n = 0; n < 60; n++) begin
      ctrl = 2'($urandom_range(0, 3));
      isw  = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 9);
      a = rnd64();
      b = rnd64();
      if (kind == 0) begin
        b = isw ? {$urandom, 32'h0} : 64'h0;
      end else if (kind == 1) begin
        a = isw ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
        b = isw ? {$urandom, 32'hFFFF_FFFF} : 64'hFFFF_FFFF_FFFF_FFFF;
      end else if (kind < 5) begin
        a = 64'($urandom_range(0, 1000));
        b = 64'($urandom_range(1, 20));
        if ($urandom_range(0, 1) == 1) a = -a;
        if ($urandom_range(0, 1) == 1) b = -b;
        if (isw) begin
          a = {$urandom, a[31:0]};
          b = {$urandom, b[31:0]};
        end
      end
      model_op("rand", ctrl, isw, a, b, $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
